// File: rtl/vram_pkg.sv
// Shared definitions for the 68000-side video RAM port.
//   state_e     : access state machine encoding
//   CPU_SLOT    : VRAC[1:0] code of the CPU slot in the VRAC rotation
//   merge_lanes : byte-lane merge used by the read-modify-write path
package vram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdAcc,
    StWrWait,
    StWrAcc,
    StAck
  } state_e;

  localparam logic [1:0] CPU_SLOT = 2'b11;

  // Replace the lanes whose (active-low) strobe is asserted with write data.
  function automatic logic [15:0] merge_lanes(input logic [15:0] rd,
                                              input logic [15:0] wd,
                                              input logic        uds_b,
                                              input logic        lds_b);
    logic [15:0] res;
    res = rd;
    if (!uds_b) res[15:8] = wd[15:8];
    if (!lds_b) res[7:0]  = wd[7:0];
    return res;
  endfunction

endpackage

// File: rtl/vram_cpu_port_if.sv
// VRAM bus handshake between the CPU port (initiator) and the video RAM block.
//   ma       : VRAM word address (byte address, bit 0 always 0)
//   vramrd_b : read strobe, active low
//   vramwr   : write strobe, active high
//   br_w_b   : buffered R/W, 1 = read
//   vbus_b   : VRAM bus ownership, active low
//   vbd_out  : write data towards VRAM
//   vbd_in   : read data from VRAM
//   vrac     : access-phase code from the clock generator
// master = CPU port, slave = video RAM side.
interface vram_cpu_port_if;
  logic [17:0] ma;
  logic        vramrd_b;
  logic        vramwr;
  logic        br_w_b;
  logic        vbus_b;
  logic [15:0] vbd_out;
  logic [15:0] vbd_in;
  logic [2:0]  vrac;

  modport master (
    output ma, vramrd_b, vramwr, br_w_b, vbus_b, vbd_out,
    input  vbd_in, vrac
  );

  modport slave (
    input  ma, vramrd_b, vramwr, br_w_b, vbus_b, vbd_out,
    output vbd_in, vrac
  );
endinterface

// File: rtl/cpu_sync.sv
// Flop-chain synchronizer for the asynchronous 68k strobes.
//   i_clk       : destination clock
//   i_rst_n     : asynchronous active-low reset; chain resets to all ones
//                 (every strobe it carries is active low, so ones = idle)
//   i_async     : asynchronous inputs
//   o_sync      : inputs delayed by SYNC_STAGES flops (legal 1..3)
module cpu_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '1;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/vram_cpu_port.sv
// 68000-side initiator for video RAM. Qualifies a decoded CPU cycle, waits for
// the CPU slot in the VRAC rotation, issues one VRAM strobe per slot, then
// returns read data and acknowledges. Byte writes are done as read-modify-write
// since the array has no byte enables.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_vramcs_b     : decoder VRAM select
//   i_as_b         : 68k address strobe
//   i_uds_b/i_lds_b: 68k data strobes (upper = D[15:8])
//   i_r_w_b        : 68k R/W, 1 = read
//   i_a            : 68k word address A[AW:1]
//   i_d_in         : 68k write data
//   o_d_out        : read data to the 68k
//   o_dtack_b      : data acknowledge
//   io_vram        : VRAM handshake (master side)
module vram_cpu_port
  import vram_pkg::*;
#(
  parameter int unsigned AW          = 13,
  parameter logic [1:0]  SLOT        = CPU_SLOT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_vramcs_b,
  input  logic            i_as_b,
  input  logic            i_uds_b,
  input  logic            i_lds_b,
  input  logic            i_r_w_b,
  input  logic [AW-1:0]   i_a,
  input  logic [15:0]     i_d_in,
  output logic [15:0]     o_d_out,
  output logic            o_dtack_b,
  vram_cpu_port_if.master io_vram
);

  // Synchronized strobes
  logic [3:0] w_sync;
  logic       w_as_b;
  logic       w_cs_b;
  logic       w_uds_b;
  logic       w_lds_b;

  cpu_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (4)
  ) u_cpu_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async ({i_as_b, i_vramcs_b, i_uds_b, i_lds_b}),
    .o_sync  (w_sync)
  );

  assign w_as_b  = w_sync[3];
  assign w_cs_b  = w_sync[2];
  assign w_uds_b = w_sync[1];
  assign w_lds_b = w_sync[0];

  logic w_start;
  logic w_slot;
  logic w_rmw_start;
  logic w_unused_vrac;

  assign w_start       = !w_as_b && !w_cs_b && (!w_uds_b || !w_lds_b);
  assign w_slot        = (io_vram.vrac[1:0] == SLOT);
  // start guarantees at least one strobe low, so "differ" means exactly one
  assign w_rmw_start   = !i_r_w_b && (w_uds_b != w_lds_b);
  assign w_unused_vrac = io_vram.vrac[2];

  state_e r_state;
  state_e w_state_next;

  logic [AW-1:0] r_addr;
  logic          r_uds_b;
  logic          r_lds_b;
  logic          r_rmw;
  logic [15:0]   r_wd;
  logic [15:0]   r_data;
  logic [15:0]   r_dout;
  // Set when the RMW read happened in a slot that is still present; the write
  // must wait for VRAC to leave the slot and come back.
  logic          r_need_gap;

  logic [17:0]   w_ma;
  assign w_ma = {{(17 - AW){1'b0}}, r_addr, 1'b0};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a synchronized AS_b rise aborts from any non-idle state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = (i_r_w_b || w_rmw_start) ? StRdWait : StWrWait;
        end
      end
      StRdWait: begin
        if (w_as_b)      w_state_next = StIdle;
        else if (w_slot) w_state_next = StRdAcc;
      end
      StRdAcc: begin
        if (w_as_b)     w_state_next = StIdle;
        else if (r_rmw) w_state_next = StWrWait;
        else            w_state_next = StAck;
      end
      StWrWait: begin
        if (w_as_b)                     w_state_next = StIdle;
        else if (w_slot && !r_need_gap) w_state_next = StWrAcc;
      end
      StWrAcc: begin
        w_state_next = w_as_b ? StIdle : StAck;
      end
      StAck: begin
        if (w_as_b) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from the state register only, so a reset drops every
  // strobe immediately.
  always_comb begin
    io_vram.ma       = '0;
    io_vram.vramrd_b = 1'b1;
    io_vram.vramwr   = 1'b0;
    io_vram.br_w_b   = 1'b1;
    io_vram.vbus_b   = 1'b1;
    io_vram.vbd_out  = '0;
    o_dtack_b        = 1'b1;
    unique case (r_state)
      StRdAcc: begin
        io_vram.ma       = w_ma;
        io_vram.vbus_b   = 1'b0;
        io_vram.vramrd_b = 1'b0;
      end
      StWrAcc: begin
        io_vram.ma      = w_ma;
        io_vram.vbus_b  = 1'b0;
        io_vram.br_w_b  = 1'b0;
        io_vram.vramwr  = 1'b1;
        io_vram.vbd_out = r_data;
      end
      StAck: begin
        o_dtack_b = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign o_d_out = r_dout;

  // Cycle datapath: latch the CPU request, capture and merge read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_uds_b    <= 1'b1;
      r_lds_b    <= 1'b1;
      r_rmw      <= 1'b0;
      r_wd       <= '0;
      r_data     <= '0;
      r_dout     <= '0;
      r_need_gap <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_addr     <= i_a;
            r_uds_b    <= w_uds_b;
            r_lds_b    <= w_lds_b;
            r_rmw      <= w_rmw_start;
            r_wd       <= i_d_in;
            r_data     <= i_d_in;
            r_need_gap <= 1'b0;
          end
        end
        StRdAcc: begin
          if (r_rmw) begin
            r_data <= merge_lanes(io_vram.vbd_in, r_wd, r_uds_b, r_lds_b);
          end else begin
            r_data <= io_vram.vbd_in;
            r_dout <= io_vram.vbd_in;
          end
          r_need_gap <= w_slot;
        end
        StWrWait: begin
          if (!w_slot) r_need_gap <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_cpu_port.sv
module tb_vram_cpu_port;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Aw         = 13;

  logic        clk;
  logic        rst_n;
  logic        vramcs_b;
  logic        as_b;
  logic        uds_b;
  logic        lds_b;
  logic        r_w_b;
  logic [12:0] a;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        dtack_b;

  vram_cpu_port_if vif ();

  vram_cpu_port #(
    .AW          (Aw),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_vramcs_b (vramcs_b),
    .i_as_b     (as_b),
    .i_uds_b    (uds_b),
    .i_lds_b    (lds_b),
    .i_r_w_b    (r_w_b),
    .i_a        (a),
    .i_d_in     (d_in),
    .o_d_out    (d_out),
    .o_dtack_b  (dtack_b),
    .io_vram    (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRAC source: free-running with random holds, or forced to a fixed code
  logic       vrac_free  = 1'b0;
  logic [2:0] vrac_force = 3'd0;

  initial begin
    vif.vrac = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if (vrac_free) begin
        if ($urandom_range(0, 3) != 0) vif.vrac = vif.vrac + 3'd1;
      end else begin
        vif.vrac = vrac_force;
      end
    end
  end

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // VRAM model and bus monitor
  logic [15:0] vmem [0:8191];
  assign vif.vbd_in = vmem[vif.ma[13:1]];

  int          rd_total = 0;
  int          wr_total = 0;
  int          viol = 0;
  int          dtack_falls = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          fall_cyc = 0;
  logic [17:0] rd_ma = '0;
  logic [17:0] wr_ma = '0;
  logic [15:0] wr_data = '0;
  logic        seen_off = 1'b1;
  logic        gap_at_wr = 1'b0;

  initial begin
    logic [2:0] prev_vrac;
    logic       prev_strobe;
    logic       prev_dtack;
    logic       rd_s;
    logic       wr_s;
    logic       strobe;
    for (int i = 0; i < 8192; i++) vmem[i] = init_word(i);
    prev_vrac   = 3'd0;
    prev_strobe = 1'b0;
    prev_dtack  = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_strobe = 1'b0;
        prev_dtack  = 1'b1;
      end else begin
        rd_s   = !vif.vramrd_b;
        wr_s   = vif.vramwr;
        strobe = rd_s || wr_s;
        if (rd_s && wr_s) viol++;
        if (vif.vbus_b == strobe) viol++;
        if (strobe && prev_strobe) viol++;
        if (strobe && prev_vrac[1:0] != 2'b11) viol++;
        if (rd_s) begin
          rd_total++;
          rd_ma    = vif.ma;
          rd_cyc   = cyc;
          seen_off = 1'b0;
          if (!vif.br_w_b) viol++;
        end
        if (wr_s) begin
          wr_total++;
          wr_ma     = vif.ma;
          wr_data   = vif.vbd_out;
          wr_cyc    = cyc;
          gap_at_wr = seen_off;
          vmem[vif.ma[13:1]] = vif.vbd_out;
          if (vif.br_w_b) viol++;
        end
        if (vif.vrac[1:0] != 2'b11) seen_off = 1'b1;
        if (!dtack_b && prev_dtack) begin
          dtack_falls++;
          fall_cyc = cyc;
        end
        prev_strobe = strobe;
        prev_dtack  = dtack_b;
      end
      prev_vrac = vif.vrac;
    end
  end

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference memory: what the VRAM should hold after every completed cycle
  logic [15:0] ref_mem [0:8191];

  task automatic cpu_idle();
    as_b     = 1'b1;
    uds_b    = 1'b1;
    lds_b    = 1'b1;
    vramcs_b = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ":dtack_b"}, 32'(dtack_b), 1);
    check_eq({tag, ":vramrd_b"}, 32'(vif.vramrd_b), 1);
    check_eq({tag, ":vramwr"}, 32'(vif.vramwr), 0);
    check_eq({tag, ":br_w_b"}, 32'(vif.br_w_b), 1);
    check_eq({tag, ":vbus_b"}, 32'(vif.vbus_b), 1);
    check_eq({tag, ":ma"}, 32'(vif.ma), 0);
    check_eq({tag, ":d_out"}, 32'(d_out), 0);
    check_eq({tag, ":vbd_out"}, 32'(vif.vbd_out), 0);
  endtask

  // One complete CPU cycle with full checking against the reference memory.
  // exp_lat != 0 also checks start-to-first-strobe latency in clocks.
  task automatic run_cycle(input string tag, input logic rw, input logic ub, input logic lb,
                           input logic [12:0] addr, input logic [15:0] wd, input int exp_lat);
    int          rd0, wr0, v0, t_start, t_rise;
    int          exp_rd_n, exp_wr_n;
    logic [15:0] old, exp_wr;
    logic [17:0] exp_ma;
    logic        got;
    logic [15:0] dout_seen;
    rd0    = rd_total;
    wr0    = wr_total;
    v0     = viol;
    old    = ref_mem[addr];
    exp_ma = {4'b0, addr, 1'b0};
    exp_wr = old;
    if (rw) begin
      exp_rd_n = 1;
      exp_wr_n = 0;
    end else if (!ub && !lb) begin
      exp_rd_n = 0;
      exp_wr_n = 1;
      exp_wr   = wd;
    end else begin
      exp_rd_n = 1;
      exp_wr_n = 1;
      if (!ub) exp_wr = (wd & 16'hFF00) | (old & 16'h00FF);
      else     exp_wr = (old & 16'hFF00) | (wd & 16'h00FF);
    end

    @(posedge clk);
    #1;
    r_w_b    = rw;
    a        = addr;
    d_in     = wd;
    uds_b    = ub;
    lds_b    = lb;
    vramcs_b = 1'b0;
    as_b     = 1'b0;
    t_start  = cyc;

    got = 1'b0;
    for (int w = 0; w < 64 && !got; w++) begin
      @(negedge clk);
      if (!dtack_b) got = 1'b1;
    end
    dout_seen = d_out;
    check_eq({tag, ":ack"}, 32'(got), 1);
    if (got) begin
      check_eq({tag, ":ack_lat"}, fall_cyc - (exp_wr_n != 0 ? wr_cyc : rd_cyc), 1);
      if (rw) check_eq({tag, ":d_out"}, 32'(dout_seen), 32'(old));
      if (exp_lat != 0) begin
        check_eq({tag, ":acc_lat"}, (exp_rd_n != 0 ? rd_cyc : wr_cyc) - t_start, exp_lat);
      end
    end

    @(posedge clk);
    #1;
    cpu_idle();
    t_rise = cyc;
    if (got) begin
      for (int w = 0; w < 16 && !dtack_b; w++) @(negedge clk);
      check_eq({tag, ":dtack_rise"}, cyc - t_rise, SyncStages + 1);
    end
    repeat (2) @(posedge clk);

    check_eq({tag, ":n_rd"}, rd_total - rd0, exp_rd_n);
    check_eq({tag, ":n_wr"}, wr_total - wr0, exp_wr_n);
    check_eq({tag, ":bus_proto"}, viol - v0, 0);
    if (exp_rd_n != 0) check_eq({tag, ":rd_ma"}, 32'(rd_ma), 32'(exp_ma));
    if (exp_wr_n != 0) begin
      check_eq({tag, ":wr_ma"}, 32'(wr_ma), 32'(exp_ma));
      check_eq({tag, ":wr_data"}, 32'(wr_data), 32'(exp_wr));
    end
    if (exp_rd_n != 0 && exp_wr_n != 0) check_eq({tag, ":rmw_gap"}, 32'(gap_at_wr), 1);
    if (!rw) ref_mem[addr] = exp_wr;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0, wr0, f0;
    logic        found;
    int          kind;
    logic [12:0] ra;
    logic [15:0] rd;

    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    r_w_b = 1'b1;
    a     = '0;
    d_in  = '0;
    cpu_idle();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n     = 1'b1;
    vrac_free = 1'b1;
    repeat (3) @(posedge clk);

    // Word write, word read, byte writes through read-modify-write
    run_cycle("wr_word", 1'b0, 1'b0, 1'b0, 13'h0010, 16'h1234, 0);
    run_cycle("wr_beef", 1'b0, 1'b0, 1'b0, 13'h0123, 16'hBEEF, 0);
    run_cycle("rd_beef", 1'b1, 1'b0, 1'b0, 13'h0123, 16'h0000, 0);
    run_cycle("seed_l", 1'b0, 1'b0, 1'b0, 13'h0040, 16'hC3A7, 0);
    run_cycle("wr_lds", 1'b0, 1'b1, 1'b0, 13'h0040, 16'h995A, 0);
    run_cycle("rd_lds", 1'b1, 1'b0, 1'b0, 13'h0040, 16'h0000, 0);
    run_cycle("seed_u", 1'b0, 1'b0, 1'b0, 13'h0040, 16'hC3A7, 0);
    run_cycle("wr_uds", 1'b0, 1'b0, 1'b1, 13'h0040, 16'h5A66, 0);
    run_cycle("rd_uds", 1'b1, 1'b0, 1'b0, 13'h0040, 16'h0000, 0);

    // Abort in WR_WAIT with VRAC held off-slot
    vrac_free  = 1'b0;
    vrac_force = 3'd0;
    repeat (2) @(posedge clk);
    rd0 = rd_total;
    wr0 = wr_total;
    f0  = dtack_falls;
    @(posedge clk);
    #1;
    r_w_b    = 1'b0;
    a        = 13'h0010;
    d_in     = 16'hDEAD;
    uds_b    = 1'b0;
    lds_b    = 1'b0;
    vramcs_b = 1'b0;
    as_b     = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    cpu_idle();
    repeat (6) @(posedge clk);
    vrac_force = 3'd3;
    repeat (6) @(posedge clk);
    check_eq("abort:n_wr", wr_total - wr0, 0);
    check_eq("abort:n_rd", rd_total - rd0, 0);
    check_eq("abort:dtack", dtack_falls - f0, 0);
    vrac_free = 1'b1;
    run_cycle("post_abort", 1'b1, 1'b0, 1'b0, 13'h0010, 16'h0000, 0);

    // Reset asserted during RD_ACC
    vrac_free  = 1'b0;
    vrac_force = 3'd0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    r_w_b    = 1'b1;
    a        = 13'h0123;
    uds_b    = 1'b0;
    lds_b    = 1'b0;
    vramcs_b = 1'b0;
    as_b     = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vrac_force = 3'd3;
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (!vif.vramrd_b) found = 1'b1;
    end
    check_eq("rst_mid:rd_seen", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    cpu_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    vrac_free = 1'b1;
    repeat (3) @(posedge clk);
    run_cycle("rst_rd", 1'b1, 1'b0, 1'b0, 13'h0123, 16'h0000, 0);

    // Slot already present at entry: ACC the clock after WAIT is entered
    vrac_free  = 1'b0;
    vrac_force = 3'd3;
    repeat (3) @(posedge clk);
    run_cycle("slot_rd", 1'b1, 1'b0, 1'b0, 13'h0010, 16'h0000, SyncStages + 2);

    // RMW write must not reuse the read's slot while VRAC sits in it
    rd0 = rd_total;
    wr0 = wr_total;
    fork
      run_cycle("rmw_hold", 1'b0, 1'b1, 1'b0, 13'h0040, 16'h0011, SyncStages + 2);
      begin
        repeat (15) @(posedge clk);
        check_eq("rmw_hold:no_wr", wr_total - wr0, 0);
        check_eq("rmw_hold:rd", rd_total - rd0, 1);
        vrac_free = 1'b1;
      end
    join

    // Randomized cycles over a small address window to force aliasing
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      ra   = 13'($urandom_range(0, 15));
      rd   = 16'($urandom);
      case (kind)
        0:       run_cycle("rnd_rd", 1'b1, 1'b0, 1'b0, ra, rd, 0);
        1:       run_cycle("rnd_ww", 1'b0, 1'b0, 1'b0, ra, rd, 0);
        2:       run_cycle("rnd_wu", 1'b0, 1'b0, 1'b1, ra, rd, 0);
        default: run_cycle("rnd_wl", 1'b0, 1'b1, 1'b0, ra, rd, 0);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
